// File: rtl/cp0_int_ctrl_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions, ExcCodes,
// controller state encoding and register packing helpers.
package cp0_int_ctrl_pkg;

  localparam logic [4:0] CP0_REG_SR    = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE = 5'd13;
  localparam logic [4:0] CP0_REG_EPC   = 5'd14;
  localparam logic [4:0] CP0_REG_PRID  = 5'd15;

  localparam int SR_IM_LSB     = 10;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IE_BIT     = 0;
  localparam int CAUSE_BD_BIT  = 31;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_EXC_LSB = 2;

  localparam logic [31:0] ERET_OPCODE = 32'h4200_0018;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HANDLER = 2'd2
  } cp0_state_e;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl, input logic ie);
    logic [31:0] v;
    v = 32'd0;
    v[SR_IM_LSB +: 6] = im;
    v[SR_EXL_BIT]     = exl;
    v[SR_IE_BIT]      = ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc_code);
    logic [31:0] v;
    v = 32'd0;
    v[CAUSE_BD_BIT]       = bd;
    v[CAUSE_IP_LSB +: 6]  = ip;
    v[CAUSE_EXC_LSB +: 5] = exc_code;
    return v;
  endfunction

endpackage

// File: rtl/cp0_int_ctrl_sync.sv
// Multi-flop synchroniser for the asynchronous hwint request lines; the last
// stage output is the Cause.IP field.
module cp0_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift chain, cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt controller: SR/Cause/EPC/PRId, interrupt acceptance, one-cycle
// intclr/handler_sel flush pulse. Optional synchronous exceptions: CP0_SYNC_EXC_EN.
module cp0_int_ctrl #(
  parameter logic [31:0] HANDLER_PC     = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL       = 32'h0000_0001,
  parameter int          HW_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [5:0]  hwint,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret_m,
`ifdef CP0_SYNC_EXC_EN
  input  logic        exc_m,
  input  logic [4:0]  exc_code_m,
`endif
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc,
  output logic        intclr,
  output logic        handler_sel
);

  import cp0_int_ctrl_pkg::*;

  cp0_state_e  state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;
  logic        flush_q, flush_d;

  logic [5:0]  ip_s;
  logic        exc_req_s;
  logic [4:0]  exc_code_s;
  logic        int_req_s;
  logic        accept_s;
  logic        sr_wr_s;
  logic        epc_wr_s;

  cp0_sync #(
    .STAGES (HW_SYNC_STAGES),
    .WIDTH  (6)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (hwint),
    .sync_o  (ip_s)
  );

`ifdef CP0_SYNC_EXC_EN
  assign exc_req_s  = exc_m;
  assign exc_code_s = exc_code_m;
`else
  assign exc_req_s  = 1'b0;
  assign exc_code_s = EXC_INT;
`endif

  assign int_req_s = ie_q & ~exl_q & ((im_q & ip_s) != 6'd0);
  assign accept_s  = (state_q == ST_IDLE) & (int_req_s | exc_req_s);
  assign sr_wr_s   = cp0_we & (cp0_addr == CP0_REG_SR);
  assign epc_wr_s  = cp0_we & (cp0_addr == CP0_REG_EPC);

  // Next-state for registers and FSM; hardware acceptance overrides mtc0 on EXL and EPC
  always_comb begin
    im_d       = im_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    state_d    = state_q;

    if (sr_wr_s) begin
      im_d = cp0_wdata[SR_IM_LSB +: 6];
      ie_d = cp0_wdata[SR_IE_BIT];
    end else begin
      im_d = im_q;
      ie_d = ie_q;
    end

    if (accept_s) begin
      exl_d = 1'b1;
    end else if (eret_m && (state_q == ST_HANDLER)) begin
      exl_d = 1'b0;
    end else if (sr_wr_s) begin
      exl_d = cp0_wdata[SR_EXL_BIT];
    end else begin
      exl_d = exl_q;
    end

    if (accept_s) begin
      bd_d       = bd_m;
      exc_code_d = exc_req_s ? exc_code_s : EXC_INT;
      epc_d      = bd_m ? (pc_m - 32'd4) : pc_m;
    end else if (epc_wr_s) begin
      epc_d = cp0_wdata;
    end else begin
      epc_d = epc_q;
    end

    // Leaving the handler is keyed on EXL going low, whether by eret or by mtc0
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        state_d = ST_HANDLER;
      end
      ST_HANDLER: begin
        if (!exl_d) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HANDLER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    flush_d = (state_d == ST_FLUSH);
  end

  // State and architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      flush_q    <= flush_d;
    end
  end

  // mfc0 read mux sees pre-edge values
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      CP0_REG_SR:    cp0_rdata = pack_sr(im_q, exl_q, ie_q);
      CP0_REG_CAUSE: cp0_rdata = pack_cause(bd_q, ip_s, exc_code_q);
      CP0_REG_EPC:   cp0_rdata = epc_q;
      CP0_REG_PRID:  cp0_rdata = PRID_VAL;
      default:       cp0_rdata = 32'd0;
    endcase
  end

  assign epc         = epc_q;
  assign intclr      = flush_q;
  assign handler_sel = flush_q;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Scoreboard bench for cp0_int_ctrl: a register-level reference model predicts
// each cycle's outputs, a monitor compares them on the falling edge.
module tb_cp0_int_ctrl;

  localparam logic [31:0] PRID = 32'h0000_0001;
  localparam int          SYNC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_v = 32'd0;
  logic        bd_v = 1'b0;
  logic [5:0]  hw_v = 6'd0;
  logic        we_v = 1'b0;
  logic [4:0]  addr_v = 5'd0;
  logic [31:0] wd_v = 32'd0;
  logic        eret_v = 1'b0;
  logic        exc_v = 1'b0;
  logic [4:0]  exc_code_v = 5'd0;
  logic [31:0] rdata;
  logic [31:0] epc;
  logic        intclr;
  logic        hsel;

  cp0_int_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .pc_m      (pc_v),
    .bd_m      (bd_v),
    .hwint     (hw_v),
    .cp0_we    (we_v),
    .cp0_addr  (addr_v),
    .cp0_wdata (wd_v),
    .eret_m    (eret_v),
`ifdef CP0_SYNC_EXC_EN
    .exc_m     (exc_v),
    .exc_code_m(exc_code_v),
`endif
    .cp0_rdata (rdata),
    .epc       (epc),
    .intclr    (intclr),
    .handler_sel(hsel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] rdata;
    logic [31:0] epc;
    logic        flush;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: architectural state, handler mode 0=idle 1=flush 2=handler
  logic [5:0]  m_im, m_ip;
  logic        m_exl, m_ie, m_bd;
  logic [4:0]  m_exc;
  logic [31:0] m_epc;
  int          m_mode;
  logic [5:0]  m_pipe[$];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic model_reset();
    m_im = 6'd0; m_ip = 6'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0;
    m_exc = 5'd0; m_epc = 32'd0; m_mode = 0;
    m_pipe = {};
    for (int i = 0; i < SYNC - 1; i++) m_pipe.push_back(6'd0);
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (a == 5'd12) begin
      v[15:10] = m_im; v[1] = m_exl; v[0] = m_ie;
    end else if (a == 5'd13) begin
      v[31] = m_bd; v[15:10] = m_ip; v[6:2] = m_exc;
    end else if (a == 5'd14) begin
      v = m_epc;
    end else if (a == 5'd15) begin
      v = PRID;
    end
    return v;
  endfunction

  task automatic model_step();
    bit req, acc, nexl;
    req  = m_ie && !m_exl && ((m_im & m_ip) != 6'd0);
    acc  = (m_mode == 0) && (req || exc_v);
    nexl = m_exl;
    if (we_v && addr_v == 5'd12) begin
      m_im = wd_v[15:10]; m_ie = wd_v[0]; nexl = wd_v[1];
    end
    if (eret_v && m_mode == 2) nexl = 1'b0;
    if (we_v && addr_v == 5'd14) m_epc = wd_v;
    if (acc) begin
      nexl  = 1'b1;
      m_bd  = bd_v;
      m_exc = exc_v ? exc_code_v : 5'd0;
      m_epc = bd_v ? pc_v - 32'd4 : pc_v;
    end
    m_exl = nexl;
    if (m_mode == 0)      m_mode = acc ? 1 : 0;
    else if (m_mode == 1) m_mode = 2;
    else                  m_mode = nexl ? 2 : 0;
    m_pipe.push_back(hw_v);
    m_ip = m_pipe.pop_front();
  endtask

  // Drive one cycle of stimulus; called just after a rising edge
  task automatic cycle(input logic [31:0] pc, input logic bd, input logic [5:0] hw,
                       input logic we, input logic [4:0] a, input logic [31:0] wd,
                       input logic er);
    exp_t e;
    pc_v = pc; bd_v = bd; hw_v = hw; we_v = we; addr_v = a; wd_v = wd; eret_v = er;
    e.addr = a; e.rdata = model_read(a); e.epc = m_epc; e.flush = (m_mode == 1);
    sb.push_back(e);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic peek(input logic [4:0] a, input logic [31:0] want, input string name);
    addr_v = a;
    #1;
    chk32(name, rdata, want);
  endtask

  task automatic leave_handler();
    repeat (3) cycle(32'h0, 1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(32'h0, 1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b1);
  endtask

  // Monitor: one expectation per cycle, compared on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk32($sformatf("rdata[%0d]", e.addr), rdata, e.rdata);
        chk32("epc", epc, e.epc);
        chk32("intclr", {31'd0, intclr}, {31'd0, e.flush});
        chk32("handler_sel", {31'd0, hsel}, {31'd0, e.flush});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses, first_idx, waited;
    model_reset();
    repeat (2) @(posedge clk);
    peek(5'd12, 32'd0, "rst_sr");
    peek(5'd15, PRID, "rst_prid");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); model_step(); #1;

    // Basic interrupt
    cycle(32'h3040, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0000_0401, 1'b0);
    pulses = 0; first_idx = -1;
    for (int i = 0; i < 6; i++) begin
      cycle(32'h3040, 1'b0, 6'd1, 1'b0, 5'd14, 32'd0, 1'b0);
      if (intclr) begin
        pulses++;
        if (first_idx < 0) first_idx = i;
      end
    end
    chk32("basic_pulses", pulses, 1);
    chk32("basic_latency", first_idx, 2);
    peek(5'd12, 32'h0000_0403, "basic_sr");
    peek(5'd13, 32'h0000_0400, "basic_cause");
    peek(5'd14, 32'h0000_3040, "basic_epc");

    // Masked while in handler, then eret re-arms
    pulses = 0;
    repeat (4) begin
      cycle(32'h3040, 1'b0, 6'd1, 1'b0, 5'd12, 32'd0, 1'b0);
      if (intclr) pulses++;
    end
    chk32("masked_pulses", pulses, 0);
    cycle(32'h3050, 1'b0, 6'd1, 1'b0, 5'd12, 32'd0, 1'b1);
    pulses = 0;
    repeat (4) begin
      cycle(32'h3050, 1'b0, 6'd1, 1'b0, 5'd12, 32'd0, 1'b0);
      if (intclr) pulses++;
    end
    chk32("eret_pulses", pulses, 1);
    leave_handler();

    // Branch delay slot
    pulses = 0;
    repeat (6) begin
      cycle(32'h3048, 1'b1, 6'd1, 1'b0, 5'd13, 32'd0, 1'b0);
      if (intclr) pulses++;
    end
    chk32("bd_pulses", pulses, 1);
    peek(5'd14, 32'h0000_3044, "bd_epc");
    peek(5'd13, 32'h8000_0400, "bd_cause");
    leave_handler();

    // mtc0 SR on the acceptance edge
    cycle(32'h3060, 1'b0, 6'd1, 1'b0, 5'd12, 32'd0, 1'b0);
    cycle(32'h3060, 1'b0, 6'd1, 1'b0, 5'd12, 32'd0, 1'b0);
    chk32("simul_pre", {31'd0, intclr}, 32'd0);
    cycle(32'h3060, 1'b0, 6'd1, 1'b1, 5'd12, 32'h0000_FC01, 1'b0);
    chk32("simul_pulse", {31'd0, intclr}, 32'd1);
    peek(5'd12, 32'h0000_FC03, "simul_sr");
    leave_handler();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r_wd;
      logic [4:0]  r_a;
      if ($urandom_range(3) == 0) hw_v = 6'($urandom);
      r_a  = ($urandom_range(1) == 0) ? 5'(12 + $urandom_range(3)) : 5'($urandom_range(31));
      r_wd = $urandom;
      if ($urandom_range(3) != 0) r_wd[0] = 1'b1;
      cycle({$urandom_range(32'h3FFF_FFFF), 2'b00}, 1'($urandom_range(1)), hw_v,
            ($urandom_range(5) == 0), r_a, r_wd, ($urandom_range(7) == 0));
    end

`ifdef CP0_SYNC_EXC_EN
    repeat (3) cycle(32'h0, 1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(32'h0, 1'b0, 6'd0, 1'b1, 5'd12, 32'd0, 1'b0);
    repeat (2) cycle(32'h0, 1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    exc_v = 1'b1; exc_code_v = 5'd12;
    cycle(32'h5000, 1'b0, 6'd0, 1'b0, 5'd13, 32'd0, 1'b0);
    exc_v = 1'b0; exc_code_v = 5'd0;
    chk32("exc_pulse", {31'd0, intclr}, 32'd1);
    peek(5'd13, 32'h0000_0030, "exc_cause");
    peek(5'd14, 32'h0000_5000, "exc_epc");
`endif

    // Asynchronous reset mid-run, readback while held
    hw_v = 6'd0; we_v = 1'b0; eret_v = 1'b0;
    @(negedge clk); #1 reset = 1'b0; #1;
    model_reset();
    chk32("rst_intclr", {31'd0, intclr}, 32'd0);
    peek(5'd12, 32'd0, "rst2_sr");
    peek(5'd13, 32'd0, "rst2_cause");
    peek(5'd14, 32'd0, "rst2_epc");
    peek(5'd15, PRID, "rst2_prid");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); model_step(); #1;

    // Reset while the flush pulse is high
    cycle(32'h3070, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0000_0401, 1'b0);
    waited = 0;
    while (!intclr && waited < 8) begin
      cycle(32'h3070, 1'b0, 6'd1, 1'b0, 5'd14, 32'd0, 1'b0);
      waited++;
    end
    chk32("flush_seen", {31'd0, intclr}, 32'd1);
    @(negedge clk); #1 reset = 1'b0; #1;
    model_reset();
    hw_v = 6'd0;
    chk32("flush_rst_intclr", {31'd0, intclr}, 32'd0);
    chk32("flush_rst_hsel", {31'd0, hsel}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); model_step(); #1;
    cycle(32'h3080, 1'b0, 6'd0, 1'b1, 5'd12, 32'h0000_0401, 1'b0);
    repeat (5) cycle(32'h3080, 1'b0, 6'd1, 1'b0, 5'd13, 32'd0, 1'b0);

    chk32("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
